// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch sequencer. It reads the PC value, fetches the
//            addressed word from a synchronous ROM, and hands the word to the
//            decoder over a valid/ready handshake. For each accepted
//            instruction it issues exactly one clean 0->1->0 pulse on the
//            PC increment input.
// Options  : define INSTR_FETCH_WRAP_STOP_EN to stop fetching, instead of
//            wrapping, once the word at address 2^SIZE-1 is accepted.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int SIZE    = 8,   // address width, equal to the PC width
    parameter int DATA_W  = 16,  // instruction word width
    parameter int MEM_LAT = 2    // ROM read latency in cycles, 1..4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SIZE-1:0]   pc_in,
    output logic              incr,
    output logic [SIZE-1:0]   mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              halt,
    output logic              busy,
    output logic              done
);

    // A 2-bit wait counter covers every legal latency (MEM_LAT-1 <= 3).
    localparam int                 c_cnt_w     = 2;
    localparam logic [c_cnt_w-1:0] c_wait_init = c_cnt_w'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_STEP    = 3'd4,
        S_SETTLE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [SIZE-1:0]     r_addr;
    logic [DATA_W-1:0]   r_instr;
    logic                r_incr;
    logic                r_mem_rd;
    logic                r_valid;
    logic                r_busy;
    logic                w_last_addr;

`ifdef INSTR_FETCH_WRAP_STOP_EN
    logic r_done;

    // The word in flight came from the top of memory.
    assign w_last_addr = &r_addr;

    // Sticky end-of-memory flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (r_state == S_PRESENT && instr_ready && w_last_addr) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;
`else
    // Without the stop option, the PC is allowed to wrap to address 0.
    assign w_last_addr = 1'b0;
    assign done        = 1'b0;
`endif

    // Next-state logic. halt is only looked at on instruction boundaries
    // (IDLE and SETTLE), so a fetch that has started always completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!halt && !done) w_next = S_ADDR;
            S_ADDR:    w_next = S_WAIT;
            S_WAIT:    if (r_cnt == '0) w_next = S_PRESENT;
            S_PRESENT: begin
                if (instr_ready) begin
                    w_next = w_last_addr ? S_IDLE : S_STEP;
                end
            end
            S_STEP:    w_next = S_SETTLE;
            S_SETTLE:  w_next = halt ? S_IDLE : S_ADDR;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register. Every output is registered from the next state, so
    // nothing glitches and incr is a clean single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_instr  <= '0;
            r_incr   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_incr   <= (w_next == S_STEP);
            r_mem_rd <= (w_next == S_ADDR);
            r_valid  <= (w_next == S_PRESENT);
            r_busy   <= (w_next != S_IDLE);

            // The address is taken from the PC on entering ADDR (the PC is
            // stable in IDLE and SETTLE) and held until the FSM returns to
            // IDLE, so the wrap check can still see it in PRESENT.
            if (w_next == S_ADDR) begin
                r_addr <= pc_in;
            end else if (w_next == S_IDLE) begin
                r_addr <= '0;
            end

            // Preloading in ADDR yields exactly MEM_LAT WAIT cycles.
            if (w_next == S_ADDR) begin
                r_cnt <= c_wait_init;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // ROM data is valid on the last WAIT cycle.
            if (r_state == S_WAIT && r_cnt == '0) begin
                r_instr <= mem_data;
            end
        end
    end

    assign incr        = r_incr;
    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_addr;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire
